// File: rtl/answer_window_ctrl.sv
// Answer-window initiator: arms the countdown timer, captures submit/abort/expiry.
// Optional low-time warning output is built when WINDOW_WARN_EN is defined.
module answer_window_ctrl #(
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned WARN_SECS    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_start,
    input  logic       submit,
    input  logic       answer_ok,
    input  logic       abort,
    input  logic       unlock,
    input  logic [3:0] time_left,
    input  logic       timer_done,
    output logic       start_timer,
    output logic       window_open,
    output logic       result_valid,
    output logic [1:0] result_code,
    output logic [3:0] captured_time,
    output logic [1:0] attempts_left,
    output logic       locked,
    output logic       warn
);

    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [1:0] MAX_A = 2'(MAX_ATTEMPTS);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    localparam logic [1:0] C_PASS    = 2'b00;
    localparam logic [1:0] C_FAIL    = 2'b01;
    localparam logic [1:0] C_TIMEOUT = 2'b10;
    localparam logic [1:0] C_ABORT   = 2'b11;

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 3 || GAP_CYCLES < 2 || WARN_SECS > 15)
    begin : g_param_check
        $error("answer_window_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_OPEN,
        S_REPORT,
        S_GAP,
        S_LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          start_timer_q, start_timer_d;
    logic          window_open_q, window_open_d;
    logic          result_valid_q, result_valid_d;
    logic [1:0]    result_code_q, result_code_d;
    logic [3:0]    captured_time_q, captured_time_d;
    logic [1:0]    attempts_left_q, attempts_left_d;
    logic          locked_q, locked_d;

    logic          end_evt;
    logic [1:0]    end_code;

    // abort outranks submit, which outranks expiry
    always_comb begin
        end_evt  = 1'b0;
        end_code = C_PASS;
        if (abort) begin
            end_evt  = 1'b1;
            end_code = C_ABORT;
        end else if (submit) begin
            end_evt  = 1'b1;
            end_code = answer_ok ? C_PASS : C_FAIL;
        end else if (timer_done) begin
            end_evt  = 1'b1;
            end_code = C_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_start) state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_OPEN;
            end
            S_OPEN: begin
                if (end_evt) state_d = S_REPORT;
            end
            S_REPORT: begin
                state_d = (attempts_left_q == 2'd0) ? S_LOCKED : S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
            end
            S_LOCKED: begin
                if (unlock) state_d = S_GAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gap_cnt_d = '0;
        if (state_q == S_GAP) gap_cnt_d = gap_cnt_q + GW'(1);
    end

    always_comb begin
        result_code_d   = result_code_q;
        captured_time_d = captured_time_q;
        attempts_left_d = attempts_left_q;
        if (state_q == S_OPEN && end_evt) begin
            result_code_d   = end_code;
            captured_time_d = time_left;
            unique case (end_code)
                C_PASS:    attempts_left_d = MAX_A;
                C_ABORT:   attempts_left_d = attempts_left_q;
                default: begin
                    if (attempts_left_q != 2'd0)
                        attempts_left_d = attempts_left_q - 2'd1;
                end
            endcase
        end
        if (state_q == S_LOCKED && unlock) attempts_left_d = MAX_A;
    end

    // status flags are registered copies of the upcoming state
    always_comb begin
        start_timer_d  = (state_d == S_ARM) || (state_d == S_OPEN);
        window_open_d  = (state_d == S_OPEN);
        result_valid_d = (state_d == S_REPORT);
        locked_d       = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q       <= '0;
            start_timer_q   <= 1'b0;
            window_open_q   <= 1'b0;
            result_valid_q  <= 1'b0;
            result_code_q   <= C_PASS;
            captured_time_q <= 4'd0;
            attempts_left_q <= MAX_A;
            locked_q        <= 1'b0;
        end else begin
            gap_cnt_q       <= gap_cnt_d;
            start_timer_q   <= start_timer_d;
            window_open_q   <= window_open_d;
            result_valid_q  <= result_valid_d;
            result_code_q   <= result_code_d;
            captured_time_q <= captured_time_d;
            attempts_left_q <= attempts_left_d;
            locked_q        <= locked_d;
        end
    end

`ifdef WINDOW_WARN_EN
    logic warn_q, warn_d;

    always_comb begin
        warn_d = (state_q == S_OPEN) && (state_d == S_OPEN) &&
                 (time_left <= 4'(WARN_SECS));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

    assign start_timer   = start_timer_q;
    assign window_open   = window_open_q;
    assign result_valid  = result_valid_q;
    assign result_code   = result_code_q;
    assign captured_time = captured_time_q;
    assign attempts_left = attempts_left_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_answer_window_ctrl.sv
// Randomised bench for answer_window_ctrl with a 10-cycle-per-second timer model.
// Checks results against a transaction-level scoreboard of attempts and codes.
module tb_answer_window_ctrl;

    localparam int MAXA  = 3;
    localparam int GAPC  = 2;
    localparam int WARNS = 3;

    localparam int K_PASS = 0;
    localparam int K_FAIL = 1;
    localparam int K_TMO  = 2;
    localparam int K_ABT  = 3;
    localparam int K_SAME = 4;
    localparam int K_RST  = 5;

    logic       clk = 1'b0;
    logic       rst, req_start, submit, answer_ok, abort, unlock, timer_done;
    logic [3:0] time_left;
    logic       start_timer, window_open, result_valid, locked, warn;
    logic [1:0] result_code, attempts_left;
    logic [3:0] captured_time;

    answer_window_ctrl #(
        .MAX_ATTEMPTS(MAXA),
        .GAP_CYCLES  (GAPC),
        .WARN_SECS   (WARNS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_start    (req_start),
        .submit       (submit),
        .answer_ok    (answer_ok),
        .abort        (abort),
        .unlock       (unlock),
        .time_left    (time_left),
        .timer_done   (timer_done),
        .start_timer  (start_timer),
        .window_open  (window_open),
        .result_valid (result_valid),
        .result_code  (result_code),
        .captured_time(captured_time),
        .attempts_left(attempts_left),
        .locked       (locked),
        .warn         (warn)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int t_tl  = 10;
    int t_sub = 0;
    bit t_run = 1'b0;
    bit t_prev = 1'b0;

    int m_att  = MAXA;
    int m_code = 0;
    int m_cap  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // countdown timer: restarts on a rising start_timer, 10 cycles per second
    task automatic timer_step(input bit st);
        bit done;
        done = 1'b0;
        if (!st) begin
            t_run = 1'b0;
            t_tl  = 10;
            t_sub = 0;
        end else if (!t_prev) begin
            t_run = 1'b1;
            t_tl  = 10;
            t_sub = 0;
        end else if (t_run) begin
            if (t_sub == 9) begin
                t_sub = 0;
                t_tl--;
                if (t_tl == 0) begin
                    t_run = 1'b0;
                    done  = 1'b1;
                end
            end else begin
                t_sub++;
            end
        end
        t_prev     = st;
        time_left  = 4'(t_tl);
        timer_done = done;
    endtask

    task automatic cyc();
        bit st;
        st = start_timer;
        @(posedge clk);
        #1;
        timer_step(st);
    endtask

    task automatic clear_inputs();
        req_start = 1'b0;
        submit    = 1'b0;
        answer_ok = 1'b0;
        abort     = 1'b0;
        unlock    = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(start_timer), 0);
        chk({tag, "_open"}, 32'(window_open), 0);
        chk({tag, "_rv"}, 32'(result_valid), 0);
        chk({tag, "_code"}, 32'(result_code), 0);
        chk({tag, "_cap"}, 32'(captured_time), 0);
        chk({tag, "_att"}, 32'(attempts_left), MAXA);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_warn"}, 32'(warn), 0);
    endtask

    task automatic run_window(input int kind, input int target, input bit drop);
        logic [3:0] prev_tl;
        bit         hit;
        int         code;
        int         cap;
        int         exp_warn;

        req_start = 1'b1;
        cyc();
        req_start = 1'b0;
        chk("arm_start", 32'(start_timer), 1);
        chk("arm_open", 32'(window_open), 0);
        cyc();
        chk("open_flag", 32'(window_open), 1);
        chk("open_start", 32'(start_timer), 1);

        prev_tl = 4'hF;
        for (int i = 0; ; i++) begin
            if (i > 300) begin
                chk("window_budget", 0, 1);
                return;
            end
`ifdef WINDOW_WARN_EN
            exp_warn = (prev_tl <= 4'(WARNS)) ? 1 : 0;
`else
            exp_warn = 0;
`endif
            chk("warn_open", 32'(warn), 32'(exp_warn));
            if (kind == K_TMO || kind == K_SAME)
                hit = timer_done;
            else
                hit = (time_left == 4'(target));
            if (hit) break;
            prev_tl = time_left;
            cyc();
            chk("still_open", 32'(window_open), 1);
        end

        cap  = int'(time_left);
        code = 0;
        case (kind)
            K_PASS: begin
                submit = 1'b1; answer_ok = 1'b1; code = 0; m_att = MAXA;
            end
            K_FAIL, K_SAME: begin
                submit = 1'b1; answer_ok = 1'b0; code = 1;
                if (m_att > 0) m_att--;
            end
            K_TMO: begin
                code = 2;
                if (m_att > 0) m_att--;
            end
            K_ABT: begin
                abort = 1'b1;
                submit = 1'($urandom_range(0, 1));
                answer_ok = 1'($urandom_range(0, 1));
                code = 3;
            end
            default: rst = 1'b1;
        endcase
        cyc();
        clear_inputs();

        if (kind == K_RST) begin
            m_att = MAXA; m_code = 0; m_cap = 0;
            chk_reset_vals("midrst");
            cyc();
            chk("midrst_no_rv", 32'(result_valid), 0);
            chk("midrst_idle", 32'(start_timer), 0);
            return;
        end

        m_code = code;
        m_cap  = cap;
        chk("rep_rv", 32'(result_valid), 1);
        chk("rep_code", 32'(result_code), 32'(m_code));
        chk("rep_cap", 32'(captured_time), 32'(m_cap));
        chk("rep_att", 32'(attempts_left), 32'(m_att));
        chk("rep_open", 32'(window_open), 0);
        chk("rep_start", 32'(start_timer), 0);
        chk("rep_warn", 32'(warn), 0);
        cyc();
        chk("post_rv", 32'(result_valid), 0);
        chk("post_code", 32'(result_code), 32'(m_code));
        chk("post_locked", 32'(locked), (m_att == 0) ? 1 : 0);

        if (m_att == 0) begin
            req_start = 1'b1; submit = 1'b1; abort = 1'b1;
            cyc();
            clear_inputs();
            repeat (3) cyc();
            chk("lock_ignore_start", 32'(start_timer), 0);
            chk("lock_hold", 32'(locked), 1);
            chk("lock_att", 32'(attempts_left), 0);
            unlock = 1'b1;
            cyc();
            unlock = 1'b0;
            m_att = MAXA;
            chk("unlock_att", 32'(attempts_left), MAXA);
            chk("unlock_locked", 32'(locked), 0);
            repeat (GAPC) cyc();
        end else begin
            repeat (GAPC - 1) cyc();
            req_start = drop;
            cyc();
            req_start = 1'b0;
            chk("gap_drop", 32'(start_timer), 0);
            if (drop) begin
                cyc();
                chk("drop_not_queued", 32'(start_timer), 0);
                chk("drop_code_held", 32'(result_code), 32'(m_code));
            end
        end
    endtask

    initial begin
        clear_inputs();
        rst        = 1'b1;
        time_left  = 4'd10;
        timer_done = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_vals("reset");

        run_window(K_PASS, 7, 1'b0);
        run_window(K_TMO, 0, 1'b0);
        run_window(K_TMO, 0, 1'b0);
        run_window(K_TMO, 0, 1'b0);
        run_window(K_SAME, 0, 1'b0);
        run_window(K_ABT, 5, 1'b1);
        run_window(K_RST, 4, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_window(int'($urandom_range(0, 5)), int'($urandom_range(1, 9)),
                       1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
